id_scoreboard: RTL and testbench
================================

ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameters SHALL be: NSTAGE, 4, number of tracked post-ID stages (2..8); LOAD_LAT, 2, first stage index whose load data is valid (0..NSTAGE-1); XLEN, 32, datapath width; CNT_W, 16, stall counter width.
REQ-002 Ports SHALL be, clock and reset first:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
issue_valid  in  1  ID holds a valid instruction
issue_we  in  1  ID instruction writes rd
issue_waddr  in  5  ID destination register
issue_is_load  in  1  ID instruction is a load
re1, re2  in  1 each  operand read enables
raddr1, raddr2  in  5 each  operand register addresses
reg_data1, reg_data2  in  XLEN each  register-file read data
fwd_wdata  in  NSTAGE*XLEN  result of stage k in slice k (stage 0 = EX)
hold  in  1  global pipeline freeze
flush  in  1  kill ID instruction
opv1, opv2  out  XLEN each  resolved operands
stallreq  out  1  load-use stall request to PC/IF/ID
stall_cnt  out  CNT_W  saturating count of stallreq cycles
busy_mask  out  NSTAGE  per-stage entry valid

Function
REQ-003 Block SHALL hold NSTAGE entries {v, waddr, is_load}; entry k tracks the instruction in post-ID stage k; busy_mask[k] = entry k v.
REQ-004 push = issue_valid & issue_we & (issue_waddr != 0) & !stallreq & !flush.
REQ-005 When hold=1, all entries and stall_cnt SHALL keep their values.
REQ-006 When hold=0, entry k SHALL load entry k-1 for k>=1 and entry NSTAGE-1 SHALL be discarded.
REQ-007 When hold=0, entry 0 SHALL load {1, issue_waddr, issue_is_load} if push, else v=0 (bubble).
REQ-008 Operand n match in stage k: ren=1, raddrn!=0, entry k v=1, entry k waddr=raddrn.
REQ-009 opvn SHALL be slice k of fwd_wdata for the lowest matching k; reg_datan if no match; 0 when ren=0 or raddrn=0.
REQ-010 Operand n not-ready: lowest matching k has is_load=1 and k<LOAD_LAT; older matches SHALL NOT be considered.
REQ-011 stallreq = issue_valid & !flush & (operand 1 not-ready | operand 2 not-ready); combinational, same cycle.
REQ-012 A stall SHALL insert a bubble in entry 0 while older entries advance, so a load-use dependency resolves after exactly LOAD_LAT-k stall cycles.
REQ-013 flush=1 SHALL suppress push and stallreq for that cycle; existing entries advance normally.
REQ-014 hold=1 and stallreq=1 together: hold SHALL take priority (no shift, no bubble, no count).
REQ-015 stall_cnt SHALL increment by 1 on each clock with stallreq=1 and hold=0, and saturate at all-ones.
REQ-016 opv1, opv2, stallreq SHALL be combinational from current inputs and entry state; all other state updates on rising clk.

Reset
REQ-017 On rst=1 at a clock edge, all entry v, waddr, is_load and stall_cnt SHALL clear to 0, taking priority over hold and push.
REQ-018 After reset, busy_mask=0 and stall_cnt=0; with entries empty, opvn=reg_datan (or 0 per REQ-009) and stallreq=0.
REQ-019 Reset asserted mid-stall SHALL drop stallreq on the following cycle (entries empty).

Verification
REQ-020 ALU chain: issue add x5 (push), next cycle read x5 with fwd_wdata[0]=0x1234, reg_data1=0xDEAD -> opv1=0x1234, stallreq=0.
REQ-021 Load-use (LOAD_LAT=2): issue lw x7, next cycle read x7 -> stallreq=1 for 2 cycles, then 0 with opv from slice 2; stall_cnt=2.
REQ-022 Youngest priority: x3 in stages 1 and 3, slices 0x11/0x33 -> opv=0x11.
REQ-023 x0 and re=0: raddr1=0 with x0-tagged entries absent, re2=0 -> opv1=0, opv2=0, no stall.
REQ-024 hold=1 for 3 cycles during load-use stall -> busy_mask and stall_cnt frozen, stallreq stays 1; resumes count after release.
REQ-025 Saturation/reset: force CNT_W=4, 20 stall cycles -> stall_cnt=0xF; rst=1 one cycle -> stall_cnt=0, busy_mask=0.

Source files
------------

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: tracks in-flight writers, forwards the youngest result, requests load-use stalls.
// Latency: operands and stall request are combinational; entry shift and stall count update on the next rising clk.
// Backpressure: stallreq holds ID (bubble pushed, older entries advance); hold freezes every piece of state.
module id_scoreboard #(
    parameter int NSTAGE   = 4,
    parameter int LOAD_LAT = 2,
    parameter int XLEN     = 32,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [4:0]               issue_waddr,
    input  logic                     issue_is_load,
    input  logic                     re1,
    input  logic                     re2,
    input  logic [4:0]               raddr1,
    input  logic [4:0]               raddr2,
    input  logic [XLEN-1:0]          reg_data1,
    input  logic [XLEN-1:0]          reg_data2,
    input  logic [NSTAGE*XLEN-1:0]   fwd_wdata,
    input  logic                     hold,
    input  logic                     flush,
    output logic [XLEN-1:0]          opv1,
    output logic [XLEN-1:0]          opv2,
    output logic                     stallreq,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [NSTAGE-1:0]        busy_mask
);

    // Result of resolving one operand against the in-flight entries.
    typedef struct packed {
        logic            nrdy;
        logic [XLEN-1:0] data;
    } opnd_t;

    // Entry k describes the instruction currently in post-ID stage k (0 = EX).
    logic [NSTAGE-1:0]      ent_v;
    logic [NSTAGE-1:0]      ent_load;
    logic [NSTAGE-1:0][4:0] ent_waddr;

    logic  push;
    opnd_t op1;
    opnd_t op2;

    // Walk from the oldest stage to the youngest so the youngest match is the
    // last one written and therefore wins. The not-ready flag is taken from
    // that same youngest match only: an older load to the same register is
    // shadowed by the younger writer and must not cause a stall.
    function automatic opnd_t lookup(
        input logic                     re,
        input logic [4:0]               ra,
        input logic [XLEN-1:0]          rdata,
        input logic [NSTAGE-1:0]        v,
        input logic [NSTAGE-1:0]        ld,
        input logic [NSTAGE-1:0][4:0]   wa,
        input logic [NSTAGE*XLEN-1:0]   fwd
    );
        opnd_t r;
        r.nrdy = 1'b0;
        r.data = rdata;
        if (!re || ra == 5'd0) begin
            r.data = '0;
        end else begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (v[k] && wa[k] == ra) begin
                    r.data = fwd[k*XLEN +: XLEN];
                    r.nrdy = ld[k] && (k < LOAD_LAT);
                end
            end
        end
        return r;
    endfunction

    // Resolve operand 1 from forwarding slices or the register file.
    always_comb begin
        op1 = lookup(re1, raddr1, reg_data1, ent_v, ent_load, ent_waddr, fwd_wdata);
    end

    // Resolve operand 2 from forwarding slices or the register file.
    always_comb begin
        op2 = lookup(re2, raddr2, reg_data2, ent_v, ent_load, ent_waddr, fwd_wdata);
    end

    // Stall and push decisions; flush kills the ID instruction outright, so it
    // neither stalls nor occupies a tracking slot. Writes to x0 are never tracked.
    always_comb begin
        stallreq = issue_valid && !flush && (op1.nrdy || op2.nrdy);
        push     = issue_valid && issue_we && (issue_waddr != 5'd0) && !stallreq && !flush;
    end

    assign opv1      = op1.data;
    assign opv2      = op2.data;
    assign busy_mask = ent_v;

    // Advance the tracking pipeline in lockstep with the datapath; a stalled
    // or empty ID slot becomes a bubble while older entries keep moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_v     <= '0;
            ent_load  <= '0;
            ent_waddr <= '0;
        end else if (!hold) begin
            ent_v     <= {ent_v[NSTAGE-2:0], push};
            ent_load  <= {ent_load[NSTAGE-2:0], push && issue_is_load};
            ent_waddr <= {ent_waddr[NSTAGE-2:0], (push ? issue_waddr : 5'd0)};
        end
    end

    // Saturating count of cycles actually lost to load-use stalls (frozen by hold).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!hold && stallreq && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based pipeline model.
// Counter width is narrowed to 4 bits so saturation is reachable quickly.
module tb_id_scoreboard;

    localparam int NSTAGE   = 4;
    localparam int LOAD_LAT = 2;
    localparam int XLEN     = 32;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst;
    logic                   issue_valid;
    logic                   issue_we;
    logic [4:0]             issue_waddr;
    logic                   issue_is_load;
    logic                   re1;
    logic                   re2;
    logic [4:0]             raddr1;
    logic [4:0]             raddr2;
    logic [XLEN-1:0]        reg_data1;
    logic [XLEN-1:0]        reg_data2;
    logic [NSTAGE*XLEN-1:0] fwd_wdata;
    logic                   hold;
    logic                   flush;
    logic [XLEN-1:0]        opv1;
    logic [XLEN-1:0]        opv2;
    logic                   stallreq;
    logic [CNT_W-1:0]       stall_cnt;
    logic [NSTAGE-1:0]      busy_mask;

    int tests = 0;
    int errs  = 0;

    id_scoreboard #(
        .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT), .XLEN(XLEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_waddr(issue_waddr), .issue_is_load(issue_is_load),
        .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
        .reg_data1(reg_data1), .reg_data2(reg_data2),
        .fwd_wdata(fwd_wdata), .hold(hold), .flush(flush),
        .opv1(opv1), .opv2(opv2), .stallreq(stallreq),
        .stall_cnt(stall_cnt), .busy_mask(busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The pipeline is a queue, element 0 the youngest stage; each advance
    // pushes the newcomer (or a bubble) at the front and drops the oldest.
    typedef struct {
        bit       v;
        bit [4:0] wa;
        bit       ld;
    } ent_t;

    ent_t pipe[$];
    int   m_cnt = 0;
    bit   armed = 0;

    function automatic void m_clear();
        ent_t e;
        e.v = 0; e.wa = 0; e.ld = 0;
        pipe.delete();
        for (int k = 0; k < NSTAGE; k++) pipe.push_back(e);
        m_cnt = 0;
    endfunction

    // First (youngest) writer of the register decides both value and readiness.
    function automatic void m_lookup(input logic re, input logic [4:0] ra,
                                     input logic [31:0] rd,
                                     output logic [31:0] val, output logic nr);
        val = rd;
        nr  = 0;
        if (!re || ra == 0) begin
            val = 0;
            return;
        end
        for (int k = 0; k < NSTAGE; k++) begin
            if (pipe[k].v && pipe[k].wa == ra) begin
                val = fwd_wdata[k*XLEN +: XLEN];
                nr  = pipe[k].ld && (k < LOAD_LAT);
                return;
            end
        end
    endfunction

    logic [31:0] e_op1, e_op2;
    logic        e_nr1, e_nr2, e_stall;
    logic [3:0]  e_busy;

    // Compare every cycle on the falling edge, then advance the model with the
    // same inputs the DUT will see at the next rising edge.
    always @(negedge clk) begin
        if (armed) begin
            m_lookup(re1, raddr1, reg_data1, e_op1, e_nr1);
            m_lookup(re2, raddr2, reg_data2, e_op2, e_nr2);
            e_stall = issue_valid && !flush && (e_nr1 || e_nr2);
            e_busy  = 0;
            for (int k = 0; k < NSTAGE; k++) e_busy[k] = pipe[k].v;
            chk("m_opv1", opv1, e_op1);
            chk("m_opv2", opv2, e_op2);
            chk("m_stallreq", {31'd0, stallreq}, {31'd0, e_stall});
            chk("m_busy_mask", {28'd0, busy_mask}, {28'd0, e_busy});
            chk("m_stall_cnt", {28'd0, stall_cnt}, m_cnt);
            if (rst) begin
                m_clear();
            end else if (!hold) begin
                ent_t e;
                e.v  = issue_valid && issue_we && issue_waddr != 0 && !e_stall && !flush;
                e.wa = e.v ? issue_waddr : 5'd0;
                e.ld = e.v && issue_is_load;
                pipe.push_front(e);
                void'(pipe.pop_back());
                if (e_stall && m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (rst) begin
            m_clear();
            armed = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_waddr = 0; issue_is_load = 0;
        re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        reg_data1 = 0; reg_data2 = 0; fwd_wdata = '0;
        hold = 0; flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic is_ld);
        idle();
        issue_valid = 1; issue_we = 1; issue_waddr = rd; issue_is_load = is_ld;
    endtask

    task automatic read1(input logic [4:0] ra);
        idle();
        issue_valid = 1; re1 = 1; raddr1 = ra;
    endtask

    initial begin
        rst = 1;
        idle();
        next_cycle();
        next_cycle();
        rst = 0;

        // Reset state, empty scoreboard passes the register file through.
        re1 = 1; raddr1 = 5'd9; reg_data1 = 32'hCAFE;
        @(negedge clk);
        chk("rst_busy", {28'd0, busy_mask}, 32'h0);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'h0);
        chk("rst_stall", {31'd0, stallreq}, 32'h0);
        chk("rst_opv1", opv1, 32'hCAFE);
        next_cycle();

        // ALU chain: forwarded from EX.
        do_reset();
        issue(5'd5, 0);
        next_cycle();
        read1(5'd5);
        fwd_wdata[0 +: XLEN] = 32'h1234; reg_data1 = 32'hDEAD;
        @(negedge clk);
        chk("alu_opv1", opv1, 32'h1234);
        chk("alu_stall", {31'd0, stallreq}, 32'h0);
        next_cycle();

        // Load-use: two stall cycles, then value from slice 2.
        do_reset();
        issue(5'd7, 1);
        next_cycle();
        read1(5'd7);
        fwd_wdata[0*XLEN +: XLEN] = 32'hAAAA;
        fwd_wdata[1*XLEN +: XLEN] = 32'hBBBB;
        fwd_wdata[2*XLEN +: XLEN] = 32'h7777;
        @(negedge clk);
        chk("lu_stall0", {31'd0, stallreq}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("lu_stall1", {31'd0, stallreq}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("lu_stall2", {31'd0, stallreq}, 32'h0);
        chk("lu_opv1", opv1, 32'h7777);
        chk("lu_cnt", {28'd0, stall_cnt}, 32'h2);
        next_cycle();

        // Youngest writer wins: x3 in stages 1 and 3.
        do_reset();
        issue(5'd3, 0); next_cycle();
        idle();         next_cycle();
        issue(5'd3, 0); next_cycle();
        idle();         next_cycle();
        read1(5'd3);
        fwd_wdata[1*XLEN +: XLEN] = 32'h11;
        fwd_wdata[3*XLEN +: XLEN] = 32'h33;
        @(negedge clk);
        chk("young_opv1", opv1, 32'h11);
        chk("young_busy", {28'd0, busy_mask}, 32'hA);
        chk("young_stall", {31'd0, stallreq}, 32'h0);
        next_cycle();

        // x0 and disabled read: both zero, no stall, x0 write not tracked.
        issue(5'd0, 1);
        re1 = 1; raddr1 = 5'd0; reg_data1 = 32'h5555;
        re2 = 0; raddr2 = 5'd3; reg_data2 = 32'h6666;
        fwd_wdata = {NSTAGE{32'h9999}};
        @(negedge clk);
        chk("x0_opv1", opv1, 32'h0);
        chk("x0_opv2", opv2, 32'h0);
        chk("x0_stall", {31'd0, stallreq}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("x0_nopush", {31'd0, busy_mask[0]}, 32'h0);

        // Hold during a load-use stall freezes state but keeps the request.
        do_reset();
        issue(5'd7, 1);
        next_cycle();
        read1(5'd7);
        @(negedge clk);
        chk("hold_stall_pre", {31'd0, stallreq}, 32'h1);
        next_cycle();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_stall", {31'd0, stallreq}, 32'h1);
            chk("hold_busy", {28'd0, busy_mask}, 32'h2);
            chk("hold_cnt", {28'd0, stall_cnt}, 32'h1);
            next_cycle();
        end
        hold = 0;
        @(negedge clk);
        chk("hold_rel_stall", {31'd0, stallreq}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("hold_done_stall", {31'd0, stallreq}, 32'h0);
        chk("hold_done_cnt", {28'd0, stall_cnt}, 32'h2);
        chk("hold_done_busy", {28'd0, busy_mask}, 32'h4);

        // Saturation: 20 stall cycles on a 4-bit counter.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            issue(5'd7, 1);
            next_cycle();
            read1(5'd7);
            next_cycle();
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("sat_cnt", {28'd0, stall_cnt}, 32'hF);

        // Reset in the middle of a stall drops stallreq next cycle.
        issue(5'd7, 1);
        next_cycle();
        read1(5'd7);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, stallreq}, 32'h1);
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("rst_after_stall", {31'd0, stallreq}, 32'h0);
        chk("rst_after_busy", {28'd0, busy_mask}, 32'h0);
        chk("rst_after_cnt", {28'd0, stall_cnt}, 32'h0);
        next_cycle();

        // Randomized traffic with a small register window to force overlaps.
        for (int c = 0; c < 4000; c++) begin
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_we      = ($urandom_range(0, 3) != 0);
            issue_waddr   = 5'($urandom_range(0, 5));
            issue_is_load = ($urandom_range(0, 4) < 2);
            re1           = ($urandom_range(0, 3) != 0);
            re2           = ($urandom_range(0, 3) != 0);
            raddr1        = 5'($urandom_range(0, 5));
            raddr2        = 5'($urandom_range(0, 5));
            reg_data1     = $urandom;
            reg_data2     = $urandom;
            for (int k = 0; k < NSTAGE; k++) fwd_wdata[k*XLEN +: XLEN] = $urandom;
            hold          = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            rst           = ($urandom_range(0, 79) == 0);
            next_cycle();
        end
        rst = 0;
        idle();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
